// File: rtl/dsp_mac_sequencer.sv
// Sequences one DSP48A1 slice as a multiply-accumulate engine over a valid/ready
// operand stream, aligning OPMODE with the slice pipeline and capturing the final P.
module dsp_mac_sequencer #(
   parameter int unsigned CNT_W   = 8,
   parameter int unsigned OPM_DLY = 1,
   parameter int unsigned P_LAT   = 3
) (
   input  logic             CLK,
   input  logic             RSTN,
   input  logic             START,
   input  logic [CNT_W-1:0] LEN,
   output logic             BUSY,
   input  logic             IN_VALID,
   output logic             IN_READY,
   input  logic [17:0]      IN_A,
   input  logic [17:0]      IN_B,
   output logic [17:0]      DSP_A,
   output logic [17:0]      DSP_B,
   output logic             DSP_CEA,
   output logic             DSP_CEB,
   output logic             DSP_CEP,
   output logic [7:0]       DSP_OPMODE,
   input  logic [47:0]      P_IN,
   output logic [47:0]      RES,
   output logic             RES_VALID
);

   localparam int unsigned OPM_W = 8;
   localparam int unsigned P_W   = 48;
   localparam int unsigned DRN_W = (P_LAT < 2) ? 1 : $clog2(P_LAT + 1);

   localparam logic [OPM_W-1:0] OPM_FIRST = 8'h01;
   localparam logic [OPM_W-1:0] OPM_ACC   = 8'h09;
   localparam logic [OPM_W-1:0] OPM_HOLD  = 8'h08;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t                        state_q, state_d;
   logic [CNT_W-1:0]              len_q, len_d;
   logic [CNT_W-1:0]              count_q, count_d;
   logic [DRN_W-1:0]              drain_q, drain_d;
   logic [P_W-1:0]                res_q, res_d;
   logic                          res_valid_q, res_valid_d;
   logic                          busy_q, busy_d;
   logic                          in_ready_q, in_ready_d;
   logic [OPM_DLY-1:0][OPM_W-1:0] opm_q, opm_d;

   logic                          accept_c;
   logic [OPM_W-1:0]              opm_in_c;
   logic [CNT_W-1:0]              count_inc_c;

   assign accept_c    = IN_VALID & in_ready_q;
   assign count_inc_c = CNT_W'(count_q + 1'b1);

   // Next-state, counters, result capture and OPMODE pipe
   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      count_d     = count_q;
      drain_d     = drain_q;
      res_d       = res_q;
      res_valid_d = 1'b0;
      opm_in_c    = OPM_HOLD;

      if (accept_c) begin
         opm_in_c = (count_q == '0) ? OPM_FIRST : OPM_ACC;
      end

      case (state_q)
         S_IDLE: begin
            if (START) begin
               if (LEN != '0) begin
                  len_d   = LEN;
                  count_d = '0;
                  state_d = S_RUN;
               end else begin
                  res_d       = '0;
                  res_valid_d = 1'b1;
               end
            end
         end
         S_RUN: begin
            if (accept_c) begin
               count_d = count_inc_c;
               if (count_inc_c == len_q) begin
                  drain_d = DRN_W'(1);
                  state_d = S_DRAIN;
               end
            end
         end
         S_DRAIN: begin
            drain_d = DRN_W'(drain_q + 1'b1);
            // P reflects the last product P_LAT edges after its accept edge
            if (drain_q == DRN_W'(P_LAT)) begin
               res_d       = P_IN;
               res_valid_d = 1'b1;
               state_d     = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d     = (state_d != S_IDLE);
      in_ready_d = (state_d == S_RUN);

      opm_d    = opm_q;
      opm_d[0] = opm_in_c;
      for (int i = 1; i < int'(OPM_DLY); i++) begin
         opm_d[i] = opm_q[i-1];
      end
   end

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         state_q     <= S_IDLE;
         len_q       <= '0;
         count_q     <= '0;
         drain_q     <= '0;
         res_q       <= '0;
         res_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         in_ready_q  <= 1'b0;
         opm_q       <= {OPM_DLY{OPM_HOLD}};
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         count_q     <= count_d;
         drain_q     <= drain_d;
         res_q       <= res_d;
         res_valid_q <= res_valid_d;
         busy_q      <= busy_d;
         in_ready_q  <= in_ready_d;
         opm_q       <= opm_d;
      end
   end

   assign BUSY       = busy_q;
   assign IN_READY   = in_ready_q;
   assign DSP_A      = IN_A;
   assign DSP_B      = IN_B;
   assign DSP_CEA    = accept_c;
   assign DSP_CEB    = accept_c;
   assign DSP_CEP    = busy_q;
   assign DSP_OPMODE = opm_q[OPM_DLY-1];
   assign RES        = res_q;
   assign RES_VALID  = res_valid_q;

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Bench for dsp_mac_sequencer: behavioural DSP48A1 slice model, table-driven jobs,
// hand-written corner sequences and a result scoreboard.
module tb_dsp_mac_sequencer;

   logic        clk = 1'b0;
   logic        rstn;
   logic        start;
   logic [7:0]  len;
   logic        busy;
   logic        in_valid;
   logic        in_ready;
   logic [17:0] in_a;
   logic [17:0] in_b;
   logic [17:0] dsp_a;
   logic [17:0] dsp_b;
   logic        dsp_cea;
   logic        dsp_ceb;
   logic        dsp_cep;
   logic [7:0]  dsp_opmode;
   logic [47:0] p_in;
   logic [47:0] res;
   logic        res_valid;

   always #5 clk = ~clk;

   dsp_mac_sequencer #(.CNT_W(8), .OPM_DLY(1), .P_LAT(3)) dut (
      .CLK        (clk),
      .RSTN       (rstn),
      .START      (start),
      .LEN        (len),
      .BUSY       (busy),
      .IN_VALID   (in_valid),
      .IN_READY   (in_ready),
      .IN_A       (in_a),
      .IN_B       (in_b),
      .DSP_A      (dsp_a),
      .DSP_B      (dsp_b),
      .DSP_CEA    (dsp_cea),
      .DSP_CEB    (dsp_ceb),
      .DSP_CEP    (dsp_cep),
      .DSP_OPMODE (dsp_opmode),
      .P_IN       (p_in),
      .RES        (res),
      .RES_VALID  (res_valid)
   );

   // Slice model: A1/B1 regs, M reg, OPMODE reg, P reg
   logic signed [17:0] a1_r  = '0;
   logic signed [17:0] b1_r  = '0;
   logic signed [35:0] m_r   = '0;
   logic [7:0]         opm_r = 8'h08;
   logic [47:0]        p_r   = '0;
   logic [47:0]        x_mux;
   logic [47:0]        z_mux;

   assign x_mux = (opm_r[1:0] == 2'b01) ? {{12{m_r[35]}}, m_r} : 48'd0;
   assign z_mux = (opm_r[3:2] == 2'b10) ? p_r : 48'd0;
   assign p_in  = p_r;

   always @(posedge clk) begin
      if (dsp_cea) a1_r <= dsp_a;
      if (dsp_ceb) b1_r <= dsp_b;
      m_r   <= a1_r * b1_r;
      opm_r <= dsp_opmode;
      if (dsp_cep) p_r <= x_mux + z_mux;
   end

   int          checks = 0;
   int          errors = 0;
   int          acc_cnt = 0;
   logic [47:0] sb[$];

   logic [17:0] job_a [8];
   logic [17:0] job_b [8];
   int          job_gap [8];
   int          job_len;

   typedef struct {
      int          len;
      logic [17:0] a0, b0, a1, b1, a2, b2;
      int          gap1;
      bit          keep_valid;
      logic [47:0] exp_res;
   } vec_t;

   vec_t vecs [6];

   task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick;
      @(negedge clk);
      #1;
   endtask

   // Scoreboard: counts accepts and checks every result strobe
   always begin
      logic [47:0] exp_v;
      @(negedge clk);
      #3;
      if (dsp_cea) acc_cnt++;
      if (res_valid) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL res_unexpected: got RES_VALID with RES=%0h, expected no result", res);
         end else begin
            exp_v = sb.pop_front();
            chk("res", res, exp_v);
         end
      end
   end

   function automatic logic [47:0] mac_model(input int n);
      logic [47:0]        sum;
      logic signed [35:0] prod;
      sum = '0;
      for (int i = 0; i < n; i++) begin
         prod = $signed(job_a[i]) * $signed(job_b[i]);
         sum  = sum + {{12{prod[35]}}, prod};
      end
      return sum;
   endfunction

   task automatic feed(input int i);
      int n;
      for (int g = 0; g < job_gap[i]; g++) begin
         in_valid = 1'b0;
         #1;
         chk("cea_bubble", 48'(dsp_cea), 48'd0);
         tick;
         chk("opm_bubble", 48'(dsp_opmode), 48'h08);
      end
      in_valid = 1'b1;
      in_a     = job_a[i];
      in_b     = job_b[i];
      n = 0;
      while (!in_ready && n < 20) begin
         tick;
         n++;
      end
      chk("ready_wait", 48'(in_ready), 48'd1);
      #1;
      chk("cea_accept", 48'(dsp_cea), 48'd1);
      chk("ceb_accept", 48'(dsp_ceb), 48'd1);
      tick;
      chk("opm_slot", 48'(dsp_opmode), (i == 0) ? 48'h01 : 48'h09);
   endtask

   task automatic wait_result(output int n);
      n = 0;
      while (!res_valid && n < 20) begin
         tick;
         n++;
      end
      chk("res_valid_seen", 48'(res_valid), 48'd1);
   endtask

   task automatic run_job(input logic [47:0] exp_res, input bit keep_valid);
      int n;
      int acc0;
      sb.push_back(exp_res);
      acc0  = acc_cnt;
      start = 1'b1;
      len   = 8'(job_len);
      tick;
      start = 1'b0;
      chk("busy_run", 48'(busy), 48'd1);
      chk("ready_run", 48'(in_ready), 48'd1);
      for (int i = 0; i < job_len; i++) feed(i);
      if (!keep_valid) in_valid = 1'b0;
      tick;
      chk("opm_drain", 48'(dsp_opmode), 48'h08);
      chk("ready_drain", 48'(in_ready), 48'd0);
      wait_result(n);
      chk("latency", 48'(n), 48'd2);
      chk("busy_done", 48'(busy), 48'd0);
      chk("accepts", 48'(acc_cnt - acc0), 48'(job_len));
   endtask

   initial begin
      int n;
      int acc0;
      int rv;

      vecs[0] = '{1, 18'd5,  18'd6,  18'd0,    18'd0,    18'd0, 18'd0, 0, 1'b1, 48'h1e};
      vecs[1] = '{3, 18'd20, 18'd10, 18'd5,    18'd6,    18'd1, 18'd1, 0, 1'b1, 48'he7};
      vecs[2] = '{3, 18'd20, 18'd10, 18'd5,    18'd6,    18'd1, 18'd1, 2, 1'b0, 48'he7};
      vecs[3] = '{1, 18'd20, 18'd10, 18'd0,    18'd0,    18'd0, 18'd0, 0, 1'b0, 48'd200};
      vecs[4] = '{1, 18'd3,  18'd4,  18'd0,    18'd0,    18'd0, 18'd0, 0, 1'b0, 48'd12};
      vecs[5] = '{2, 18'h3fffd, 18'd7, 18'd1000, 18'd1000, 18'd0, 18'd0, 1, 1'b0, 48'd999979};

      rstn = 1'b0; start = 1'b0; len = '0; in_valid = 1'b0; in_a = '0; in_b = '0;
      repeat (2) tick;
      chk("rst_res", res, 48'd0);
      chk("rst_res_valid", 48'(res_valid), 48'd0);
      chk("rst_busy", 48'(busy), 48'd0);
      chk("rst_ready", 48'(in_ready), 48'd0);
      chk("rst_opmode", 48'(dsp_opmode), 48'h08);
      chk("rst_cep", 48'(dsp_cep), 48'd0);
      rstn = 1'b1;
      tick;

      // Table jobs run back-to-back, each started in the previous RES_VALID cycle
      for (int v = 0; v < 6; v++) begin
         job_len = vecs[v].len;
         job_a[0] = vecs[v].a0; job_b[0] = vecs[v].b0; job_gap[0] = 0;
         job_a[1] = vecs[v].a1; job_b[1] = vecs[v].b1; job_gap[1] = vecs[v].gap1;
         job_a[2] = vecs[v].a2; job_b[2] = vecs[v].b2; job_gap[2] = 0;
         run_job(vecs[v].exp_res, vecs[v].keep_valid);
      end

      // Zero-length job
      in_valid = 1'b0;
      tick;
      sb.push_back(48'd0);
      start = 1'b1;
      len   = 8'd0;
      tick;
      start = 1'b0;
      chk("len0_res_valid", 48'(res_valid), 48'd1);
      chk("len0_busy", 48'(busy), 48'd0);
      chk("len0_ready", 48'(in_ready), 48'd0);
      tick;
      chk("len0_pulse_end", 48'(res_valid), 48'd0);
      chk("len0_busy_after", 48'(busy), 48'd0);

      // START during RUN must be ignored
      job_len = 3;
      job_a[0] = 18'd20; job_b[0] = 18'd10; job_gap[0] = 0;
      job_a[1] = 18'd5;  job_b[1] = 18'd6;  job_gap[1] = 0;
      job_a[2] = 18'd1;  job_b[2] = 18'd1;  job_gap[2] = 0;
      sb.push_back(48'd231);
      acc0  = acc_cnt;
      start = 1'b1;
      len   = 8'd3;
      tick;
      start = 1'b0;
      feed(0);
      in_valid = 1'b0;
      start    = 1'b1;
      len      = 8'd1;
      tick;
      start = 1'b0;
      chk("midrun_opm_bubble", 48'(dsp_opmode), 48'h08);
      chk("midrun_busy", 48'(busy), 48'd1);
      feed(1);
      feed(2);
      in_valid = 1'b0;
      tick;
      wait_result(n);
      chk("midrun_latency", 48'(n), 48'd2);
      chk("midrun_accepts", 48'(acc_cnt - acc0), 48'd3);

      // Random jobs checked against the accumulation model
      for (int r = 0; r < 3; r++) begin
         job_len = $urandom_range(1, 8);
         for (int i = 0; i < 8; i++) begin
            job_a[i]   = 18'($urandom);
            job_b[i]   = 18'($urandom);
            job_gap[i] = $urandom_range(0, 2);
         end
         run_job(mac_model(job_len), 1'($urandom_range(0, 1)));
      end

      // Reset asserted during DRAIN of a LEN=2 job
      in_valid = 1'b0;
      tick;
      job_len = 2;
      job_a[0] = 18'd7; job_b[0] = 18'd9; job_gap[0] = 0;
      job_a[1] = 18'd2; job_b[1] = 18'd3; job_gap[1] = 0;
      start = 1'b1;
      len   = 8'd2;
      tick;
      start = 1'b0;
      feed(0);
      feed(1);
      in_valid = 1'b0;
      tick;
      chk("pre_rst_busy", 48'(busy), 48'd1);
      rstn = 1'b0;
      #1;
      chk("mid_rst_res", res, 48'd0);
      chk("mid_rst_res_valid", 48'(res_valid), 48'd0);
      chk("mid_rst_busy", 48'(busy), 48'd0);
      chk("mid_rst_opmode", 48'(dsp_opmode), 48'h08);
      repeat (2) tick;
      rstn = 1'b1;
      rv = 0;
      for (int k = 0; k < 8; k++) begin
         tick;
         if (res_valid) rv++;
      end
      chk("no_res_after_rst", 48'(rv), 48'd0);
      chk("idle_after_rst", 48'(busy), 48'd0);

      job_len = 1;
      job_a[0] = 18'd3; job_b[0] = 18'd4; job_gap[0] = 0;
      run_job(48'd12, 1'b0);

      in_valid = 1'b0;
      repeat (3) tick;
      chk("sb_drained", 48'(sb.size()), 48'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
